// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush controller for the 5-stage LC-3b pipeline.
// Generates the register loads, the NOP-insert strobes and the PC mux select.
// Sequences a redirect that arrives while an I-cache fetch is still in flight.
// Keeps saturating performance counters.
module pipeline_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bubble_enable,
  input  logic             icache_req,
  input  logic             icache_resp,
  input  logic             dcache_req,
  input  logic             dcache_resp,
  input  logic             branch_taken,
  input  logic             clear_counters,
  output logic             load_pc,
  output logic [1:0]       pc_sel,
  output logic             save_target,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t state, state_nxt;
  logic   mem_stall, fetch_stall;
  logic   inc_stall, inc_bubble, inc_flush;

  assign mem_stall   = dcache_req & ~dcache_resp;
  assign fetch_stall = icache_req & ~icache_resp;

  // State register; DRAIN covers a redirect waiting on a wrong-path fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // Next-state and control outputs; all controls are forced low during reset.
  always_comb begin
    state_nxt    = state;
    load_pc      = 1'b0;
    pc_sel       = 2'b00;
    save_target  = 1'b0;
    load_if_id   = 1'b0;
    load_id_ex   = 1'b0;
    load_ex_mem  = 1'b0;
    load_mem_wb  = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    inc_bubble   = 1'b0;
    inc_flush    = 1'b0;
    case (state)
      RUN: begin
        if (mem_stall) begin
          // whole pipe freezes
        end else if (branch_taken) begin
          inc_flush    = 1'b1;
          load_if_id   = 1'b1;
          load_id_ex   = 1'b1;
          load_ex_mem  = 1'b1;
          load_mem_wb  = 1'b1;
          flush_if_id  = 1'b1;
          flush_id_ex  = 1'b1;
          flush_ex_mem = 1'b1;
          if (!fetch_stall) begin
            load_pc = 1'b1;
            pc_sel  = 2'b01;
          end else begin
            // Fetch can't be aborted: park the target and redirect later.
            save_target = 1'b1;
            state_nxt   = DRAIN;
          end
        end else if (bubble_enable) begin
          inc_bubble  = 1'b1;
          load_id_ex  = 1'b1;
          flush_id_ex = 1'b1;
          load_ex_mem = 1'b1;
          load_mem_wb = 1'b1;
        end else if (fetch_stall) begin
          load_if_id  = 1'b1;
          flush_if_id = 1'b1;
          load_id_ex  = 1'b1;
          load_ex_mem = 1'b1;
          load_mem_wb = 1'b1;
        end else begin
          load_pc     = 1'b1;
          load_if_id  = 1'b1;
          load_id_ex  = 1'b1;
          load_ex_mem = 1'b1;
          load_mem_wb = 1'b1;
        end
      end
      DRAIN: begin
        // Younger stages already hold NOPs, so branch/bubble are ignored.
        load_id_ex  = ~mem_stall;
        load_ex_mem = ~mem_stall;
        load_mem_wb = ~mem_stall;
        load_if_id  = ~mem_stall;
        flush_if_id = 1'b1;
        if (icache_resp) begin
          // Wrong-path word is discarded; PC takes the saved redirect.
          load_pc   = 1'b1;
          pc_sel    = 2'b10;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
    if (!rst_n) begin
      load_pc      = 1'b0;
      pc_sel       = 2'b00;
      save_target  = 1'b0;
      load_if_id   = 1'b0;
      load_id_ex   = 1'b0;
      load_ex_mem  = 1'b0;
      load_mem_wb  = 1'b0;
      flush_if_id  = 1'b0;
      flush_id_ex  = 1'b0;
      flush_ex_mem = 1'b0;
    end
  end

  assign inc_stall = mem_stall | (fetch_stall & (state == RUN));

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Performance counters: saturate at all-ones; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      bubble_count <= '0;
      flush_count  <= '0;
    end else if (clear_counters) begin
      stall_cycles <= '0;
      bubble_count <= '0;
      flush_count  <= '0;
    end else begin
      if (inc_stall)  stall_cycles <= sat_inc(stall_cycles);
      if (inc_bubble) bubble_count <= sat_inc(bubble_count);
      if (inc_flush)  flush_count  <= sat_inc(flush_count);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a 32-bit instance for the functional
// scenarios plus a 4-bit-counter instance that shares its inputs for saturation.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic rst_n, bubble_enable, icache_req, icache_resp, dcache_req, dcache_resp;
  logic branch_taken, clear_counters;

  logic load_pc, save_target, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic flush_if_id, flush_id_ex, flush_ex_mem;
  logic [1:0]  pc_sel;
  logic [31:0] stall_cycles, bubble_count, flush_count;

  logic load_pc4, save_target4, load_if_id4, load_id_ex4, load_ex_mem4, load_mem_wb4;
  logic flush_if_id4, flush_id_ex4, flush_ex_mem4;
  logic [1:0] pc_sel4;
  logic [3:0] stall_cycles4, bubble_count4, flush_count4;

  int pass_cnt = 0;
  int total    = 0;

  // {load_pc, pc_sel, save_target, load_if_id, load_id_ex, load_ex_mem,
  //  load_mem_wb, flush_if_id, flush_id_ex, flush_ex_mem}
  logic [10:0] ctl, ctl4;
  assign ctl  = {load_pc, pc_sel, save_target, load_if_id, load_id_ex, load_ex_mem,
                 load_mem_wb, flush_if_id, flush_id_ex, flush_ex_mem};
  assign ctl4 = {load_pc4, pc_sel4, save_target4, load_if_id4, load_id_ex4, load_ex_mem4,
                 load_mem_wb4, flush_if_id4, flush_id_ex4, flush_ex_mem4};

  localparam logic [10:0] C_IDLE   = 11'b0_00_0_0000_000;
  localparam logic [10:0] C_RUN    = 11'b1_00_0_1111_000;
  localparam logic [10:0] C_BUBBLE = 11'b0_00_0_0111_010;
  localparam logic [10:0] C_BR     = 11'b1_01_0_1111_111;
  localparam logic [10:0] C_BR_SAV = 11'b0_00_1_1111_111;
  localparam logic [10:0] C_DRAIN  = 11'b0_00_0_1111_100;
  localparam logic [10:0] C_REDIR  = 11'b1_10_0_1111_100;

  pipeline_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bubble_enable(bubble_enable),
    .icache_req(icache_req), .icache_resp(icache_resp),
    .dcache_req(dcache_req), .dcache_resp(dcache_resp),
    .branch_taken(branch_taken), .clear_counters(clear_counters),
    .load_pc(load_pc), .pc_sel(pc_sel), .save_target(save_target),
    .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
    .stall_cycles(stall_cycles), .bubble_count(bubble_count), .flush_count(flush_count)
  );

  pipeline_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bubble_enable(bubble_enable),
    .icache_req(icache_req), .icache_resp(icache_resp),
    .dcache_req(dcache_req), .dcache_resp(dcache_resp),
    .branch_taken(branch_taken), .clear_counters(clear_counters),
    .load_pc(load_pc4), .pc_sel(pc_sel4), .save_target(save_target4),
    .load_if_id(load_if_id4), .load_id_ex(load_id_ex4),
    .load_ex_mem(load_ex_mem4), .load_mem_wb(load_mem_wb4),
    .flush_if_id(flush_if_id4), .flush_id_ex(flush_id_ex4), .flush_ex_mem(flush_ex_mem4),
    .stall_cycles(stall_cycles4), .bubble_count(bubble_count4), .flush_count(flush_count4)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    bubble_enable = 0; icache_req = 0; icache_resp = 0; dcache_req = 0;
    dcache_resp = 0; branch_taken = 0; clear_counters = 0;
  endtask

  task automatic clear_all();
    idle_inputs(); clear_counters = 1; step(); clear_counters = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; idle_inputs();
    repeat (2) step();
    @(negedge clk);
    total++; if (ctl !== C_IDLE) $display("FAIL reset_ctl got=%b exp=%b", ctl, C_IDLE); else pass_cnt++;
    step(); rst_n = 1;
    // Enter DRAIN: branch while the fetch is outstanding.
    branch_taken = 1; icache_req = 1;
    @(negedge clk);
    total++; if (ctl !== C_BR_SAV) $display("FAIL rst_enter_drain got=%b exp=%b", ctl, C_BR_SAV); else pass_cnt++;
    step(); branch_taken = 0;
    @(negedge clk);
    total++; if (ctl !== C_DRAIN) $display("FAIL rst_in_drain got=%b exp=%b", ctl, C_DRAIN); else pass_cnt++;
    // Asynchronous reset mid-cycle while in DRAIN.
    #2 rst_n = 0; #1;
    total++; if (ctl !== C_IDLE) $display("FAIL rst_async_ctl got=%b exp=%b", ctl, C_IDLE); else pass_cnt++;
    total++; if (flush_count !== 0) $display("FAIL rst_async_cnt got=%0d exp=0", flush_count); else pass_cnt++;
    step(); rst_n = 1; idle_inputs();
    @(negedge clk);
    total++; if (ctl !== C_RUN) $display("FAIL rst_release_run got=%b exp=%b", ctl, C_RUN); else pass_cnt++;
    total++;
    if ({stall_cycles, bubble_count, flush_count} !== 96'd0)
      $display("FAIL rst_counters got=%0d/%0d/%0d exp=0/0/0", stall_cycles, bubble_count, flush_count);
    else pass_cnt++;
    step();
  endtask

  task automatic test_load_use();
    bubble_enable = 1;
    @(negedge clk);
    total++; if (ctl !== C_BUBBLE) $display("FAIL lu_ctl got=%b exp=%b", ctl, C_BUBBLE); else pass_cnt++;
    step(); bubble_enable = 0;
    total++; if (bubble_count !== 1) $display("FAIL lu_count got=%0d exp=1", bubble_count); else pass_cnt++;
    @(negedge clk);
    total++; if (ctl !== C_RUN) $display("FAIL lu_after got=%b exp=%b", ctl, C_RUN); else pass_cnt++;
    step();
  endtask

  task automatic test_dcache_miss();
    clear_all();
    dcache_req = 1; bubble_enable = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (ctl !== C_IDLE) $display("FAIL dmiss_stall%0d got=%b exp=%b", i, ctl, C_IDLE); else pass_cnt++;
      step();
    end
    dcache_resp = 1;
    @(negedge clk);
    total++; if (ctl !== C_BUBBLE) $display("FAIL dmiss_bubble got=%b exp=%b", ctl, C_BUBBLE); else pass_cnt++;
    step(); idle_inputs();
    total++; if (stall_cycles !== 3) $display("FAIL dmiss_stall_cnt got=%0d exp=3", stall_cycles); else pass_cnt++;
    total++; if (bubble_count !== 1) $display("FAIL dmiss_bubble_cnt got=%0d exp=1", bubble_count); else pass_cnt++;
  endtask

  task automatic test_branch();
    clear_all();
    branch_taken = 1;
    @(negedge clk);
    total++; if (ctl !== C_BR) $display("FAIL br_ctl got=%b exp=%b", ctl, C_BR); else pass_cnt++;
    step(); branch_taken = 0;
    total++; if (flush_count !== 1) $display("FAIL br_count got=%0d exp=1", flush_count); else pass_cnt++;
    @(negedge clk);
    total++; if (ctl !== C_RUN) $display("FAIL br_stay_run got=%b exp=%b", ctl, C_RUN); else pass_cnt++;
    step();
  endtask

  task automatic test_branch_drain();
    clear_all();
    branch_taken = 1; icache_req = 1;
    @(negedge clk);
    total++; if (ctl !== C_BR_SAV) $display("FAIL bd_save got=%b exp=%b", ctl, C_BR_SAV); else pass_cnt++;
    step(); branch_taken = 0;
    @(negedge clk);
    total++; if (ctl !== C_DRAIN) $display("FAIL bd_wait1 got=%b exp=%b", ctl, C_DRAIN); else pass_cnt++;
    step(); branch_taken = 1; bubble_enable = 1; // ignored in DRAIN
    @(negedge clk);
    total++; if (ctl !== C_DRAIN) $display("FAIL bd_wait2 got=%b exp=%b", ctl, C_DRAIN); else pass_cnt++;
    step(); branch_taken = 0; bubble_enable = 0; icache_resp = 1;
    @(negedge clk);
    total++; if (ctl !== C_REDIR) $display("FAIL bd_redirect got=%b exp=%b", ctl, C_REDIR); else pass_cnt++;
    step(); idle_inputs();
    @(negedge clk);
    total++; if (ctl !== C_RUN) $display("FAIL bd_back_run got=%b exp=%b", ctl, C_RUN); else pass_cnt++;
    // Only the RUN-state fetch stall counts; DRAIN cycles and ignored inputs do not.
    total++;
    if ({stall_cycles, bubble_count, flush_count} !== {32'd1, 32'd0, 32'd1})
      $display("FAIL bd_counters got=%0d/%0d/%0d exp=1/0/1", stall_cycles, bubble_count, flush_count);
    else pass_cnt++;
    step();
  endtask

  task automatic test_saturation();
    clear_all();
    dcache_req = 1;
    repeat (19) step();
    @(negedge clk);
    total++; if (ctl4 !== C_IDLE) $display("FAIL sat_ctl4 got=%b exp=%b", ctl4, C_IDLE); else pass_cnt++;
    step();
    total++; if (stall_cycles4 !== 4'd15) $display("FAIL sat_cnt4 got=%0d exp=15", stall_cycles4); else pass_cnt++;
    total++; if (stall_cycles !== 20) $display("FAIL sat_cnt32 got=%0d exp=20", stall_cycles); else pass_cnt++;
    clear_counters = 1; // concurrent with a stall cycle
    step(); clear_counters = 0;
    total++; if (stall_cycles4 !== 4'd0) $display("FAIL sat_clear4 got=%0d exp=0", stall_cycles4); else pass_cnt++;
    total++; if (stall_cycles !== 0) $display("FAIL sat_clear32 got=%0d exp=0", stall_cycles); else pass_cnt++;
    step();
    total++; if (stall_cycles4 !== 4'd1) $display("FAIL sat_restart got=%0d exp=1", stall_cycles4); else pass_cnt++;
    total++;
    if ({bubble_count4, flush_count4} !== 8'd0)
      $display("FAIL sat_other4 got=%0d/%0d exp=0/0", bubble_count4, flush_count4);
    else pass_cnt++;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_dcache_miss();
    test_branch();
    test_branch_drain();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
